// File: rtl/dbus_pkg.sv
// Shared constants for the cpu32 data-port responder: I/O page base,
// register offsets within the page, and CTL/STAT bit positions.
package dbus_pkg;

    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

    localparam logic [7:0] OFF_LED   = 8'h00;
    localparam logic [7:0] OFF_COUNT = 8'h04;
    localparam logic [7:0] OFF_CMP   = 8'h08;
    localparam logic [7:0] OFF_CTL   = 8'h0C;
    localparam logic [7:0] OFF_TXD   = 8'h10;
    localparam logic [7:0] OFF_STAT  = 8'h14;

    localparam int unsigned CTL_EN   = 0;
    localparam int unsigned CTL_PEND = 1;
    localparam int unsigned CTL_IE   = 2;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_CNT_LSB = 2;
    localparam int unsigned STAT_OVF     = 5;

endpackage

// File: rtl/sync_fifo.sv
// Plain synchronous FIFO with asynchronous reset of the pointers.
// Ports: clk, reset (async, active-high), push/din, pop, dout (head entry),
// full, empty, count (0..2^AW). A push while full is only taken when a pop
// happens in the same cycle; the parent decides what to do with drops.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-port responder for cpu32: word RAM plus an I/O page holding LEDs,
// a compare timer with interrupt, and a byte TX FIFO.
// Ports: clk, reset (async, active-high); d_addr/d_data_w/d_we from the core,
// d_data_r combinational read data; leds, irq to the board; tx_data/tx_valid/
// tx_ready handshake to the external serial transmitter.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data_w,
    input  logic        d_we,
    output logic [31:0] d_data_r,
    output logic [7:0]  leds,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    // Address decode
    logic              ram_sel;
    logic              io_sel;
    logic [7:0]        io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign ram_sel          = (d_addr[31:RAM_AW+2] == '0);
    assign io_sel           = (d_addr[31:8] == IO_BASE[31:8]);
    assign io_off           = {d_addr[7:2], 2'b00};
    assign ram_idx          = d_addr[RAM_AW+1:2];
    assign unused_addr_bits = ^d_addr[1:0];

    logic wr_led, wr_count, wr_cmp, wr_ctl, wr_txd, wr_stat;
    assign wr_led   = d_we & io_sel & (io_off == OFF_LED);
    assign wr_count = d_we & io_sel & (io_off == OFF_COUNT);
    assign wr_cmp   = d_we & io_sel & (io_off == OFF_CMP);
    assign wr_ctl   = d_we & io_sel & (io_off == OFF_CTL);
    assign wr_txd   = d_we & io_sel & (io_off == OFF_TXD);
    assign wr_stat  = d_we & io_sel & (io_off == OFF_STAT);

    // Data RAM: async read, sync write; a write during reset is dropped.
    logic [31:0] ram [RAM_WORDS];
    always_ff @(posedge clk) begin
        if (d_we && ram_sel && !reset) begin
            ram[ram_idx] <= d_data_w;
        end
    end

    // TX FIFO and overflow detection
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               tx_drop;
    logic [FIFO_AW:0]   fifo_count;

    assign tx_valid  = ~fifo_empty;
    assign fifo_pop  = tx_valid & tx_ready;
    assign fifo_push = wr_txd & (~fifo_full | fifo_pop);
    assign tx_drop   = wr_txd & ~fifo_push;

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (d_data_w[7:0]),
        .pop   (fifo_pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register state
    logic [31:0] count_q;
    logic [31:0] cmp_q;
    logic        en_q;
    logic        ie_q;
    logic        pend_q;
    logic        ovf_q;

    // Next PEND/IE: match on pre-update COUNT; a set beats a same-cycle clear.
    logic match;
    logic pend_d;
    logic ie_d;
    logic ovf_d;
    always_comb begin
        match  = en_q && (count_q == cmp_q);
        pend_d = pend_q;
        ie_d   = ie_q;
        ovf_d  = ovf_q;
        if (wr_ctl) begin
            ie_d = d_data_w[CTL_IE];
            if (d_data_w[CTL_PEND]) pend_d = 1'b0;
        end
        if (match) pend_d = 1'b1;
        if (wr_stat && d_data_w[STAT_OVF]) ovf_d = 1'b0;
        if (tx_drop) ovf_d = 1'b1;
    end

    // LED, timer, CTL and OVF registers; irq tracks PEND & IE as registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds    <= '0;
            count_q <= '0;
            cmp_q   <= '1;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_led) leds <= d_data_w[7:0];
            count_q <= wr_count ? d_data_w : count_q + 32'd1;
            if (wr_cmp) cmp_q <= d_data_w;
            if (wr_ctl) en_q <= d_data_w[CTL_EN];
            ie_q   <= ie_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            irq    <= pend_d & ie_d;
        end
    end

    // Status and control read views
    logic [31:0] stat_rd;
    logic [31:0] ctl_rd;
    always_comb begin
        stat_rd = '0;
        stat_rd[STAT_FULL]  = fifo_full;
        stat_rd[STAT_EMPTY] = fifo_empty;
        stat_rd[STAT_CNT_LSB +: FIFO_AW+1] = fifo_count;
        stat_rd[STAT_OVF]   = ovf_q;
        ctl_rd = '0;
        ctl_rd[CTL_EN]   = en_q;
        ctl_rd[CTL_PEND] = pend_q;
        ctl_rd[CTL_IE]   = ie_q;
    end

    // Read mux; unmapped and unused offsets read zero.
    always_comb begin
        d_data_r = '0;
        if (ram_sel) begin
            d_data_r = ram[ram_idx];
        end else if (io_sel) begin
            case (io_off)
                OFF_LED:   d_data_r = {24'd0, leds};
                OFF_COUNT: d_data_r = count_q;
                OFF_CMP:   d_data_r = cmp_q;
                OFF_CTL:   d_data_r = ctl_rd;
                OFF_STAT:  d_data_r = stat_rd;
                default:   d_data_r = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench for dbus_responder: stimulus queues expectations, a
// negedge monitor pops and compares them and checks every TX handshake.
module tb_dbus_responder;
    import dbus_pkg::*;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;
    localparam int K_LED = 2;
    localparam int K_TXV = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_addr;
    logic [31:0] d_data_w;
    logic        d_we;
    logic [31:0] d_data_r;
    logic [7:0]  leds;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    sb_t        sb[$];
    logic [7:0] tx_exp[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    dbus_responder #(.RAM_AW(10), .FIFO_AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .d_addr   (d_addr),
        .d_data_w (d_data_w),
        .d_we     (d_we),
        .d_data_r (d_data_r),
        .leds     (leds),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Monitor: compare queued expectations and TX handshakes mid-cycle.
    always @(negedge clk) begin
        sb_t         e;
        logic [31:0] act;
        logic [7:0]  tx_want;
        string       nm;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RD:    begin act = d_data_r;        nm = "read";     end
                K_IRQ:   begin act = {31'd0, irq};      nm = "irq";      end
                K_LED:   begin act = {24'd0, leds};     nm = "leds";     end
                default: begin act = {31'd0, tx_valid}; nm = "tx_valid"; end
            endcase
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s addr=%08h got=%08h want=%08h t=%0t", nm, e.addr, act, e.exp, $time);
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            n_chk++;
            if (tx_exp.size() == 0) begin
                n_fail++;
                $display("FAIL tx_data unexpected byte got=%02h want=none t=%0t", tx_data, $time);
            end else begin
                tx_want = tx_exp.pop_front();
                if (tx_data !== tx_want) begin
                    n_fail++;
                    $display("FAIL tx_data got=%02h want=%02h t=%0t", tx_data, tx_want, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        d_addr   = a;
        d_data_w = d;
        d_we     = 1'b1;
        step();
        d_we     = 1'b0;
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [31:0] e);
        d_addr = a;
        sb.push_back('{K_RD, a, e});
    endtask

    task automatic exp_sig(input int k, input logic [31:0] e);
        sb.push_back('{k, 32'd0, e});
    endtask

    // Raise tx_ready until the FIFO drains, with a cycle budget.
    task automatic drain();
        int n = 0;
        tx_ready = 1'b1;
        while (tx_valid && n < 16) begin
            step();
            n++;
        end
        tx_ready = 1'b0;
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout got tx_valid=%b want=0", tx_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        d_addr   = 32'd0;
        d_data_w = 32'd0;
        d_we     = 1'b0;
        tx_ready = 1'b0;
        step();
        // Reset state
        exp_rd(IO_BASE + 32'(OFF_CMP), 32'hFFFF_FFFF);
        exp_sig(K_LED, 0);
        exp_sig(K_IRQ, 0);
        exp_sig(K_TXV, 0);
        step();
        reset = 1'b0;
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h02);
        step();

        // RAM
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        exp_rd(32'h0000_0010, 32'hDEAD_BEEF); step();
        exp_rd(32'h0000_0013, 32'hDEAD_BEEF); step();
        exp_rd(32'h0000_1000, 32'h0);         step();
        wr(32'h0000_0000, 32'h1111_1111);
        exp_rd(32'h0000_0000, 32'h1111_1111); step();

        // LED
        wr(IO_BASE + 32'(OFF_LED), 32'h1A5);
        exp_sig(K_LED, 32'hA5);
        exp_rd(IO_BASE + 32'(OFF_LED), 32'hA5); step();

        // Timer match and interrupt
        wr(IO_BASE + 32'(OFF_COUNT), 32'h100);
        wr(IO_BASE + 32'(OFF_CMP), 32'd5);
        wr(IO_BASE + 32'(OFF_CTL), 32'h5);
        wr(IO_BASE + 32'(OFF_COUNT), 32'd0);
        exp_rd(IO_BASE + 32'(OFF_COUNT), 32'd0); step();
        repeat (4) step();
        exp_rd(IO_BASE + 32'(OFF_COUNT), 32'd5);
        exp_sig(K_IRQ, 0); step();
        exp_sig(K_IRQ, 1);
        exp_rd(IO_BASE + 32'(OFF_CTL), 32'h7); step();
        wr(IO_BASE + 32'(OFF_CTL), 32'h7);
        exp_sig(K_IRQ, 0);
        exp_rd(IO_BASE + 32'(OFF_CTL), 32'h5); step();

        // Clear in the same cycle as a match: set wins
        wr(IO_BASE + 32'(OFF_CMP), 32'h23);
        wr(IO_BASE + 32'(OFF_COUNT), 32'h20);
        step(); step();
        exp_rd(IO_BASE + 32'(OFF_COUNT), 32'h22); step();
        wr(IO_BASE + 32'(OFF_CTL), 32'h7);
        exp_sig(K_IRQ, 1);
        exp_rd(IO_BASE + 32'(OFF_CTL), 32'h7); step();
        wr(IO_BASE + 32'(OFF_CTL), 32'h2);
        exp_sig(K_IRQ, 0);
        exp_rd(IO_BASE + 32'(OFF_CTL), 32'h0); step();

        // FIFO fill, overflow, OVF clear, drain
        wr(IO_BASE + 32'(OFF_TXD), 32'h41);
        exp_sig(K_TXV, 1);
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h04); step();
        wr(IO_BASE + 32'(OFF_TXD), 32'h42);
        wr(IO_BASE + 32'(OFF_TXD), 32'h43);
        wr(IO_BASE + 32'(OFF_TXD), 32'h44);
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h11); step();
        wr(IO_BASE + 32'(OFF_TXD), 32'h45);
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h31); step();
        wr(IO_BASE + 32'(OFF_STAT), 32'h20);
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h11); step();
        tx_exp.push_back(8'h41); tx_exp.push_back(8'h42);
        tx_exp.push_back(8'h43); tx_exp.push_back(8'h44);
        drain();
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h02);
        exp_sig(K_TXV, 0); step();

        // Full FIFO with simultaneous push and pop
        wr(IO_BASE + 32'(OFF_TXD), 32'h51);
        wr(IO_BASE + 32'(OFF_TXD), 32'h52);
        wr(IO_BASE + 32'(OFF_TXD), 32'h53);
        wr(IO_BASE + 32'(OFF_TXD), 32'h54);
        tx_exp.push_back(8'h51); tx_exp.push_back(8'h52); tx_exp.push_back(8'h53);
        tx_exp.push_back(8'h54); tx_exp.push_back(8'h55);
        tx_ready = 1'b1;
        wr(IO_BASE + 32'(OFF_TXD), 32'h55);
        tx_ready = 1'b0;
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h11); step();
        drain();
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h02); step();

        // Reset mid-stream with three bytes queued
        wr(IO_BASE + 32'(OFF_TXD), 32'h61);
        wr(IO_BASE + 32'(OFF_TXD), 32'h62);
        wr(IO_BASE + 32'(OFF_TXD), 32'h63);
        reset = 1'b1;
        exp_sig(K_TXV, 0);
        exp_sig(K_LED, 0);
        exp_sig(K_IRQ, 0);
        exp_rd(IO_BASE + 32'(OFF_CMP), 32'hFFFF_FFFF); step();
        reset = 1'b0;
        exp_rd(32'h0000_0010, 32'hDEAD_BEEF); step();
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h02); step();

        // Unmapped address and unused I/O offset
        wr(IO_BASE + 32'(OFF_LED), 32'h3C);
        wr(32'h8000_0000, 32'h1234);
        exp_rd(32'h8000_0000, 32'h0); step();
        wr(IO_BASE + 32'h18, 32'h1234);
        exp_rd(IO_BASE + 32'h18, 32'h0);
        exp_sig(K_LED, 32'h3C); step();
        exp_rd(32'h0000_0000, 32'h1111_1111); step();
        exp_rd(IO_BASE + 32'(OFF_CMP), 32'hFFFF_FFFF); step();
        exp_rd(IO_BASE + 32'(OFF_TXD), 32'h0); step();
        exp_rd(IO_BASE + 32'(OFF_STAT), 32'h02); step();

        step();
        n_chk++;
        if (sb.size() != 0 || tx_exp.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got sb=%0d tx=%0d want 0 0", sb.size(), tx_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
